timersignal_gen: RTL

Parametrised multi-channel timer-signal generator. Drives CHANNELS independent rectangular outputs with per-channel period and high time. Each channel runs periodic or one-shot, can be retriggered or stopped, and reports completion with a one-cycle pulse. Generalises the single-output timer-signal block: it replaces the fixed division with run-time period/duty control and adds channel count, modes and status.

---
 rtl/timersignal_gen.sv | 124 ++++++++++++
 1 files changed

// File: rtl/timersignal_gen.sv
// Multi-channel timer-signal generator: per-channel period/high-time, periodic or one-shot.
// Define TIMERSIGNAL_PRESCALE_EN to advance channel counters only on a shared PRE_DIV tick.
module timersignal_gen #(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 16,
    parameter int PRE_DIV  = 4
) (
    input  logic                      tsin,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       start,
    input  logic [CHANNELS-1:0]       stop,
    input  logic [CHANNELS-1:0]       mode,
    input  logic [CHANNELS*CNT_W-1:0] period,
    input  logic [CHANNELS*CNT_W-1:0] high,
    output logic [CHANNELS-1:0]       tsout,
    output logic [CHANNELS-1:0]       busy,
    output logic [CHANNELS-1:0]       done
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic tick;

`ifdef TIMERSIGNAL_PRESCALE_EN
    localparam int PRE_W = (PRE_DIV > 1) ? $clog2(PRE_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRE_DIV - 1);

    logic [PRE_W-1:0] pre;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge tsin) begin
        if (!reset)
            pre <= '0;
        else if (pre == PRE_LAST)
            pre <= '0;
        else
            pre <= pre + PRE_W'(1);
    end

    assign tick = (pre == PRE_LAST);
`else
    // Without the prescaler every edge is an advance event.
    assign tick = (PRE_DIV >= 1);
`endif

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        state_t           state, state_nx;
        logic [CNT_W-1:0] cnt, cnt_nx;
        logic [CNT_W-1:0] per_l, per_nx;
        logic [CNT_W-1:0] hi_l, hi_nx;
        logic             mode_l, mode_nx;
        logic             out_q, out_nx;
        logic             done_q, done_nx;
        logic [CNT_W-1:0] per_in, hi_in;

        assign per_in = period[g*CNT_W +: CNT_W];
        assign hi_in  = high[g*CNT_W +: CNT_W];

        always_comb begin
            // NOTE: every output of this block gets a default first, so no path can infer a latch.
            state_nx = state;
            cnt_nx   = cnt;
            per_nx   = per_l;
            hi_nx    = hi_l;
            mode_nx  = mode_l;
            out_nx   = out_q;
            done_nx  = 1'b0;

            if (stop[g]) begin
                state_nx = IDLE;
                out_nx   = 1'b0;
            end else if (start[g] && (per_in != '0)) begin
                per_nx   = per_in;
                hi_nx    = hi_in;
                mode_nx  = mode[g];
                cnt_nx   = '0;
                state_nx = RUN;
                out_nx   = (hi_in != '0);
            end else if ((state == RUN) && tick) begin
                if (cnt == per_l - ONE) begin
                    done_nx = 1'b1;
                    cnt_nx  = '0;
                    if (mode_l) begin
                        state_nx = IDLE;
                        out_nx   = 1'b0;
                    end else begin
                        out_nx   = (hi_l != '0);
                    end
                end else begin
                    // cnt < per_l-1 here, so cnt+1 cannot overflow CNT_W bits.
                    cnt_nx = cnt + ONE;
                    out_nx = (cnt + ONE < hi_l);
                end
            end
        end

        always_ff @(posedge tsin) begin
            if (!reset) begin
                state  <= IDLE;
                cnt    <= '0;
                per_l  <= '0;
                hi_l   <= '0;
                mode_l <= 1'b0;
                out_q  <= 1'b0;
                done_q <= 1'b0;
            end else begin
                state  <= state_nx;
                cnt    <= cnt_nx;
                per_l  <= per_nx;
                hi_l   <= hi_nx;
                mode_l <= mode_nx;
                out_q  <= out_nx;
                done_q <= done_nx;
            end
        end

        assign tsout[g] = out_q;
        assign busy[g]  = (state == RUN);
        assign done[g]  = done_q;
    end

endmodule
